// File: rtl/gsensor_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : gsensor_spi_responder
// Purpose  : Emulates the accelerometer end of the G-sensor SPI link.
//            4-wire SPI mode 3 (CPOL=1, CPHA=1), ADXL345-style framing:
//            the command byte is {RW, MB, A[5:0]}, sent MSB first.
//            The SPI pins are oversampled on the system clock.
//            Supports register read/write, multi-byte auto-increment, a
//            per-transaction data snapshot, and the DATA_READY interrupt.
// Ports    : clk, reset_n              - system clock, async active-low reset
//            spi_csn/sclk/sdi          - SPI inputs from the initiator
//            spi_sdo, spi_sdo_oe       - SPI output and its drive enable
//            sample_x/y/z, sample_valid- scripted sample input, 1-cycle strobe
//            int1                      - DATA_READY interrupt, active high
//            reg_power_ctl             - current POWER_CTL register (0x2D)
//            reg_data_format           - current DATA_FORMAT register (0x31)
// Revision : 1.0 - initial release
// ============================================================================
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        int1,
    output logic [7:0]  reg_power_ctl,
    output logic [7:0]  reg_data_format
);

    localparam logic [7:0] C_BW_RATE_RST = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_csn_d;
    logic                   r_sclk_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // csn and sclk idle high, so reset there to avoid a false edge
            r_csn_sync  <= '1;
            r_sclk_sync <= '1;
            r_sdi_sync  <= '0;
            r_csn_d     <= 1'b1;
            r_sclk_d    <= 1'b1;
        end else begin
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            r_csn_d     <= r_csn_sync[SYNC_STAGES-1];
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    logic w_csn_s;
    logic w_sclk_s;
    logic w_sdi_s;
    logic w_csn_fall;
    logic w_csn_rise;
    logic w_sclk_fall;
    logic w_sclk_rise;

    assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
    assign w_csn_fall  = ~w_csn_s &  r_csn_d;
    assign w_csn_rise  =  w_csn_s & ~r_csn_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_shift_in;     // MOSI bits received so far in this byte
    logic [7:0]  r_shift_out;    // MISO bits still to be driven
    logic        r_rw;
    logic        r_mb;
    logic [5:0]  r_addr;
    logic        r_sdo;
    logic        r_oe;
    logic        r_data_read;    // a DATAx register was read in this frame
    logic [7:0]  r_bw_rate;
    logic [7:0]  r_power_ctl;
    logic [7:0]  r_int_enable;
    logic [7:0]  r_data_format;
    logic [47:0] r_live;         // {Z, Y, X}, updated by sample_valid
    logic [47:0] r_snap;         // copy of r_live frozen at csn fall
    logic        r_data_ready;

    logic [7:0]  w_shift_byte;
    logic [7:0]  w_rd_byte;
    logic        w_is_data_addr;

    assign w_shift_byte   = {r_shift_in, w_sdi_s};
    assign w_is_data_addr = (r_addr >= 6'h32) && (r_addr <= 6'h37);

    // Register read mux; sample data always comes from the snapshot so a
    // multi-byte read cannot mix old and new samples.
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_addr)
            6'h00:   w_rd_byte = DEVID;
            6'h2C:   w_rd_byte = r_bw_rate;
            6'h2D:   w_rd_byte = r_power_ctl;
            6'h2E:   w_rd_byte = r_int_enable;
            6'h31:   w_rd_byte = r_data_format;
            6'h32:   w_rd_byte = r_snap[7:0];
            6'h33:   w_rd_byte = r_snap[15:8];
            6'h34:   w_rd_byte = r_snap[23:16];
            6'h35:   w_rd_byte = r_snap[31:24];
            6'h36:   w_rd_byte = r_snap[39:32];
            6'h37:   w_rd_byte = r_snap[47:40];
            default: w_rd_byte = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_bitcnt      <= 3'd0;
            r_shift_in    <= 7'd0;
            r_shift_out   <= 8'd0;
            r_rw          <= 1'b0;
            r_mb          <= 1'b0;
            r_addr        <= 6'd0;
            r_sdo         <= 1'b0;
            r_oe          <= 1'b0;
            r_data_read   <= 1'b0;
            r_snap        <= 48'd0;
            r_bw_rate     <= C_BW_RATE_RST;
            r_power_ctl   <= 8'h00;
            r_int_enable  <= 8'h00;
            r_data_format <= 8'h00;
        end else if (w_csn_rise) begin
            // End of frame from any state; a partial byte is dropped
            r_state     <= ST_IDLE;
            r_bitcnt    <= 3'd0;
            r_sdo       <= 1'b0;
            r_oe        <= 1'b0;
            r_data_read <= 1'b0;
        end else if (w_csn_fall) begin
            r_state     <= ST_CMD;
            r_bitcnt    <= 3'd0;
            r_sdo       <= 1'b0;
            r_oe        <= 1'b0;
            r_data_read <= 1'b0;
            r_snap      <= r_live;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        r_shift_in <= w_shift_byte[6:0];
                        r_bitcnt   <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_rw    <= w_shift_byte[7];
                            r_mb    <= w_shift_byte[6];
                            r_addr  <= w_shift_byte[5:0];
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_rw) begin
                        // bitcnt==0 on a fall marks the first bit of a byte
                        if (w_sclk_fall) begin
                            if (r_bitcnt == 3'd0) begin
                                r_sdo       <= w_rd_byte[7];
                                r_shift_out <= {w_rd_byte[6:0], 1'b0};
                                r_oe        <= 1'b1;
                                if (w_is_data_addr) begin
                                    r_data_read <= 1'b1;
                                end
                            end else begin
                                r_sdo       <= r_shift_out[7];
                                r_shift_out <= {r_shift_out[6:0], 1'b0};
                            end
                        end
                        if (w_sclk_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7 && r_mb) begin
                                r_addr <= r_addr + 6'd1;
                            end
                        end
                    end else if (w_sclk_rise) begin
                        r_shift_in <= w_shift_byte[6:0];
                        r_bitcnt   <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            case (r_addr)
                                6'h2C:   r_bw_rate     <= w_shift_byte;
                                6'h2D:   r_power_ctl   <= w_shift_byte;
                                6'h2E:   r_int_enable  <= w_shift_byte;
                                6'h31:   r_data_format <= w_shift_byte;
                                default: ;
                            endcase
                            if (r_mb) begin
                                r_addr <= r_addr + 6'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Live sample registers and DATA_READY
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live       <= 48'd0;
            r_data_ready <= 1'b0;
        end else begin
            if (sample_valid) begin
                r_live <= {sample_z, sample_y, sample_x};
            end
            // A new sample wins over the clear from a finishing data read
            if (sample_valid) begin
                r_data_ready <= 1'b1;
            end else if (w_csn_rise && r_data_read) begin
                r_data_ready <= 1'b0;
            end
        end
    end

    assign spi_sdo         = r_sdo;
    assign spi_sdo_oe      = r_oe;
    assign int1            = r_data_ready & r_int_enable[7];
    assign reg_power_ctl   = r_power_ctl;
    assign reg_data_format = r_data_format;

endmodule
`default_nettype wire

// File: tb/tb_gsensor_spi_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gsensor_spi_responder
// Purpose  : Self-checking bench for gsensor_spi_responder. The stimulus
//            process drives SPI frames and pushes the expected read bytes
//            into a queue; a monitor watching the SPI pins assembles each
//            byte the responder sends and compares it against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsensor_spi_responder;

    localparam int HALF = 5;   // SCLK half-period in clk cycles
    localparam int GAP  = 4;   // csn-high gap between frames in clk cycles

    logic        clk          = 1'b0;
    logic        reset_n      = 1'b0;
    logic        spi_csn      = 1'b1;
    logic        spi_sclk     = 1'b1;
    logic        spi_sdi      = 1'b0;
    logic        spi_sdo;
    logic        spi_sdo_oe;
    logic [15:0] sample_x     = 16'h0000;
    logic [15:0] sample_y     = 16'h0000;
    logic [15:0] sample_z     = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        int1;
    logic [7:0]  reg_power_ctl;
    logic [7:0]  reg_data_format;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];

    gsensor_spi_responder #(
        .DEVID       (8'hE5),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .spi_csn         (spi_csn),
        .spi_sclk        (spi_sclk),
        .spi_sdi         (spi_sdi),
        .spi_sdo         (spi_sdo),
        .spi_sdo_oe      (spi_sdo_oe),
        .sample_x        (sample_x),
        .sample_y        (sample_y),
        .sample_z        (sample_z),
        .sample_valid    (sample_valid),
        .int1            (int1),
        .reg_power_ctl   (reg_power_ctl),
        .reg_data_format (reg_data_format)
    );

    always #20 clk = ~clk;   // 25 MHz

    // ------------------------------------------------------------------
    // Monitor: samples MISO on each SCLK rise, like the real initiator
    // ------------------------------------------------------------------
    int         mon_bit = 0;
    logic       mon_rw  = 1'b0;
    logic [7:0] mon_rx  = 8'h00;
    logic [7:0] mon_exp = 8'h00;
    logic       mon_oe_all = 1'b1;
    logic       mon_oe_any = 1'b0;

    initial begin
        forever begin
            @(posedge spi_sclk or posedge spi_csn);
            if (spi_csn) begin
                mon_bit = 0;
            end else begin
                if (mon_bit % 8 == 0) begin
                    mon_oe_all = 1'b1;
                    mon_oe_any = 1'b0;
                end
                if (mon_bit == 0) mon_rw = spi_sdi;
                mon_rx     = {mon_rx[6:0], spi_sdo};
                mon_oe_all = mon_oe_all & spi_sdo_oe;
                mon_oe_any = mon_oe_any | spi_sdo_oe;
                if (mon_bit % 8 == 7) begin
                    n_vec++;
                    if (mon_bit == 7) begin
                        if (mon_oe_any !== 1'b0) begin
                            n_err++;
                            $display("FAIL cmd_oe: oe seen during command byte, got %b required 0", mon_oe_any);
                        end
                    end else if (mon_rw) begin
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL rd_byte: got %h with no expected byte queued", mon_rx);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            if (mon_rx !== mon_exp || mon_oe_all !== 1'b1) begin
                                n_err++;
                                $display("FAIL rd_byte: got %h (oe_all=%b) required %h (oe_all=1)", mon_rx, mon_oe_all, mon_exp);
                            end
                        end
                    end else if (mon_oe_any !== 1'b0) begin
                        n_err++;
                        $display("FAIL wr_oe: oe seen during write data byte, got %b required 0", mon_oe_any);
                    end
                end
                mon_bit++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic pulse_sample();
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        spi_sclk = 1'b0;
        spi_sdi  = b;
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // One frame: command byte, then ndata_bits bits of wdata (repeated per
    // byte). sv_mid pulses sample_valid after the first data byte; sv_end
    // pulses it on the cycle the responder acts on the csn rise.
    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] wdata,
                             input int ndata_bits, input bit sv_mid, input bit sv_end);
        spi_csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(cmd[7-i]);
        for (int i = 0; i < ndata_bits; i++) begin
            if (sv_mid && i == 8) pulse_sample();
            send_bit(wdata[7 - (i % 8)]);
        end
        repeat (HALF) @(negedge clk);
        spi_csn = 1'b1;
        if (sv_end) begin
            @(negedge clk);
            @(negedge clk);
            pulse_sample();
        end
        repeat (GAP) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_sdo",         {15'd0, spi_sdo},     16'h0000);
        chk("rst_oe",          {15'd0, spi_sdo_oe},  16'h0000);
        chk("rst_int1",        {15'd0, int1},        16'h0000);
        chk("rst_power_ctl",   {8'd0, reg_power_ctl},   16'h0000);
        chk("rst_data_format", {8'd0, reg_data_format}, 16'h0000);

        // DEVID read, MB=0, two bytes re-read the same address
        exp_q.push_back(8'hE5); exp_q.push_back(8'hE5);
        spi_frame(8'h80, 8'h00, 16, 0, 0);

        // POWER_CTL write then read back
        spi_frame(8'h2D, 8'h08, 8, 0, 0);
        chk("power_ctl_wr", {8'd0, reg_power_ctl}, 16'h0008);
        exp_q.push_back(8'h08);
        spi_frame(8'hAD, 8'h00, 8, 0, 0);

        // DEVID is read-only
        spi_frame(8'h00, 8'h55, 8, 0, 0);
        exp_q.push_back(8'hE5);
        spi_frame(8'h80, 8'h00, 8, 0, 0);

        // DATA_FORMAT write, BW_RATE reset value
        spi_frame(8'h31, 8'h0B, 8, 0, 0);
        chk("data_format_wr", {8'd0, reg_data_format}, 16'h000B);
        exp_q.push_back(8'h0A);
        spi_frame(8'hAC, 8'h00, 8, 0, 0);

        // Sample load and 6-byte MB read of X/Y/Z
        sample_x = 16'h1234; sample_y = 16'hFF80; sample_z = 16'h0001;
        pulse_sample();
        chk("int1_masked", {15'd0, int1}, 16'h0000);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        spi_frame(8'hF2, 8'h00, 48, 0, 0);

        // Interrupt: enable, set, clear by reading DATAX0
        spi_frame(8'h2E, 8'h80, 8, 0, 0);
        chk("int1_after_clear_read", {15'd0, int1}, 16'h0000);
        pulse_sample();
        chk("int1_set", {15'd0, int1}, 16'h0001);
        exp_q.push_back(8'h34);
        spi_frame(8'hB2, 8'h00, 8, 0, 0);
        chk("int1_cleared", {15'd0, int1}, 16'h0000);

        // sample_valid coinciding with the clear keeps int1 high
        pulse_sample();
        exp_q.push_back(8'h34);
        spi_frame(8'hB2, 8'h00, 8, 0, 1);
        chk("int1_set_wins", {15'd0, int1}, 16'h0001);
        exp_q.push_back(8'h34);
        spi_frame(8'hB2, 8'h00, 8, 0, 0);
        chk("int1_cleared2", {15'd0, int1}, 16'h0000);

        // New sample mid-read: this frame sees the snapshot, next sees new
        sample_x = 16'hABCD; sample_y = 16'h0102; sample_z = 16'h8000;
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        spi_frame(8'hF2, 8'h00, 48, 1, 0);
        exp_q.push_back(8'hCD); exp_q.push_back(8'hAB);
        exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h80);
        spi_frame(8'hF2, 8'h00, 48, 0, 0);

        // Auto-increment wraps 0x3F -> 0x00
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hE5);
        spi_frame(8'hFE, 8'h00, 24, 0, 0);

        // MB write across POWER_CTL and INT_ENABLE
        spi_frame(8'h6D, 8'h04, 16, 0, 0);
        chk("power_ctl_mb", {8'd0, reg_power_ctl}, 16'h0004);
        exp_q.push_back(8'h04);
        spi_frame(8'hAE, 8'h00, 8, 0, 0);

        // Aborted write after 5 data bits leaves POWER_CTL alone
        spi_frame(8'h2D, 8'hFF, 5, 0, 0);
        chk("power_ctl_abort", {8'd0, reg_power_ctl}, 16'h0004);
        exp_q.push_back(8'h04);
        spi_frame(8'hAD, 8'h00, 8, 0, 0);

        repeat (10) @(negedge clk);
        chk("exp_queue_drained", exp_q.size()[15:0], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #4ms;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
